// File: rtl/fifo_stream_ctrl_pkg.sv
// Shared definitions for the line-buffer stream controller: FSM encoding and
// window geometry constants.
package fifo_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int KSIZE = 3;
    localparam int MIN_W = 3;

endpackage

// File: rtl/fifo_stream_ctrl.sv
// Drives the line-buffer fifo as a fixed-length line delay for a raster pixel
// stream and flags when its three taps hold a complete 3x3 window column.
module fifo_stream_ctrl
    import fifo_stream_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ADDR_BIT = 4,
    parameter int ROW_BIT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_BIT:0]   img_width,
    input  logic [ROW_BIT-1:0]  img_height,
    input  logic                pix_valid,
    input  logic [WIDTH-1:0]    pix_data,
    output logic                pix_ready,
    output logic                fifo_wen,
    output logic                fifo_ren,
    output logic [WIDTH-1:0]    fifo_in,
    output logic [ADDR_BIT:0]   fifo_depth,
    input  logic                fifo_full,
    input  logic [ADDR_BIT:0]   fifo_count,
    output logic                win_valid,
    output logic [ROW_BIT-1:0]  win_row,
    output logic [ADDR_BIT:0]   win_col,
    output logic                frame_done,
    output logic                cfg_err
);

    localparam int DEPTH = 2 ** ADDR_BIT;
    localparam int CW    = ADDR_BIT + 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_width;
    logic [ROW_BIT-1:0]  r_height;
    logic [CW-1:0]       r_col;
    logic [ROW_BIT-1:0]  r_row;
    logic                r_win_valid;
    logic [ROW_BIT-1:0]  r_win_row;
    logic [CW-1:0]       r_win_col;
    logic                r_frame_done;
    logic                r_cfg_err;

    logic                w_cfg_ok;
    logic                w_launch;
    logic                w_ready;
    logic                w_accept;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_fill_done;
    logic                w_win_hit;

    assign w_cfg_ok = (img_width >= CW'(MIN_W)) && (img_width <= CW'(DEPTH))
                   && (img_height >= ROW_BIT'(KSIZE));
    assign w_launch = start && (r_state == S_IDLE) && w_cfg_ok;

    // Once streaming, each push is paired with a pop, so a full fifo must not stall.
    assign w_ready  = ((r_state == S_FILL) || (r_state == S_STREAM))
                   && (!fifo_full || (r_state == S_STREAM));
    assign w_accept = pix_valid && w_ready;

    assign w_last_col  = (r_col == CW'(r_width - CW'(1)));
    assign w_last_row  = (r_row == ROW_BIT'(r_height - ROW_BIT'(1)));
    // Compared as >= so leftover occupancy from a previous frame cannot strand FILL.
    assign w_fill_done = w_accept
                      && (({1'b0, fifo_count} + (CW + 1)'(1)) >= {1'b0, r_width});
    assign w_win_hit   = w_accept && (r_row >= ROW_BIT'(KSIZE - 1))
                      && (r_col >= CW'(KSIZE - 1));

    assign pix_ready  = w_ready;
    assign fifo_wen   = w_accept;
    assign fifo_ren   = w_accept && (r_state == S_STREAM);
    assign fifo_in    = w_accept ? pix_data : '0;
    assign fifo_depth = r_width;
    assign win_valid  = r_win_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;
    assign cfg_err    = r_cfg_err;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_launch) w_state_next = S_FILL;
            S_FILL:   if (w_fill_done) w_state_next = S_STREAM;
            S_STREAM: if (w_accept && w_last_row && w_last_col) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_width      <= '0;
            r_height     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err    <= start && (r_state == S_IDLE) && !w_cfg_ok;
            r_frame_done <= (r_state == S_STREAM) && (w_state_next == S_DONE);
            r_win_valid  <= w_win_hit;
            r_win_row    <= w_win_hit ? r_row : '0;
            r_win_col    <= w_win_hit ? r_col : '0;

            if (w_launch) begin
                r_width  <= img_width;
                r_height <= img_height;
                r_col    <= '0;
                r_row    <= '0;
            end else if (w_accept) begin
                if (w_last_col) begin
                    r_col <= '0;
                    if (!w_last_row) r_row <= r_row + ROW_BIT'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// Directed bench for fifo_stream_ctrl with a behavioural line-buffer fifo model.
module tb_fifo_stream_ctrl;

    localparam int WIDTH    = 8;
    localparam int ADDR_BIT = 4;
    localparam int ROW_BIT  = 8;
    localparam int DEPTH    = 16;
    localparam int CW       = ADDR_BIT + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [CW-1:0]       img_width = '0;
    logic [ROW_BIT-1:0]  img_height = '0;
    logic                pix_valid = 1'b0;
    logic [WIDTH-1:0]    pix_data = '0;
    logic                pix_ready;
    logic                fifo_wen;
    logic                fifo_ren;
    logic [WIDTH-1:0]    fifo_in;
    logic [CW-1:0]       fifo_depth;
    logic                fifo_full;
    logic [CW-1:0]       m_count;
    logic                win_valid;
    logic [ROW_BIT-1:0]  win_row;
    logic [CW-1:0]       win_col;
    logic                frame_done;
    logic                cfg_err;

    always #5 clk = ~clk;

    fifo_stream_ctrl #(.WIDTH(WIDTH), .ADDR_BIT(ADDR_BIT), .ROW_BIT(ROW_BIT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .fifo_wen(fifo_wen), .fifo_ren(fifo_ren), .fifo_in(fifo_in),
        .fifo_depth(fifo_depth), .fifo_full(fifo_full), .fifo_count(m_count),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    int cur_w = 8;

    // Line-buffer model: popped pixel must be the one pushed cur_w writes earlier.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] popped;
    int n_bad_data = 0;
    assign fifo_full = (m_count >= CW'(DEPTH));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_count <= '0;
        end else begin
            if (fifo_ren) begin
                if (q.size() == 0) begin
                    n_bad_data++;
                end else begin
                    popped = q.pop_front();
                    if (popped != WIDTH'(fifo_in - WIDTH'(cur_w))) n_bad_data++;
                end
            end
            if (fifo_wen) q.push_back(fifo_in);
            m_count <= CW'(q.size());
        end
    end

    // Event monitor, sampled mid-cycle.
    int n_wen = 0, n_bad_ren = 0, n_win = 0, n_bad_win = 0, n_done = 0;
    int n_err = 0, n_ready = 0, n_full_ready = 0;
    int frame_wen = 0, frame_max = 0, done_wen = 0, exp_r = 2, exp_c = 2;

    always @(negedge clk) begin
        if (start) begin
            exp_r = 2; exp_c = 2; frame_wen = 0; frame_max = 0;
        end else begin
            if (fifo_ren && (!fifo_wen || frame_wen < cur_w)) n_bad_ren++;
            if (fifo_wen) begin n_wen++; frame_wen++; end
            if (int'(m_count) > frame_max) frame_max = int'(m_count);
            if (pix_ready) n_ready++;
            if (fifo_full && pix_ready) n_full_ready++;
            if (win_valid) begin
                n_win++;
                if (int'(win_row) != exp_r || int'(win_col) != exp_c) n_bad_win++;
                exp_c++;
                if (exp_c == cur_w) begin exp_c = 2; exp_r++; end
            end
            if (frame_done) begin n_done++; done_wen = frame_wen; end
            if (cfg_err) n_err++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int b_wen, b_bad_ren, b_win, b_bad_win, b_done, b_err, b_ready, b_full_ready, b_data;

    task automatic snap();
        b_wen = n_wen; b_bad_ren = n_bad_ren; b_win = n_win; b_bad_win = n_bad_win;
        b_done = n_done; b_err = n_err; b_ready = n_ready; b_full_ready = n_full_ready;
        b_data = n_bad_data;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; pix_valid = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input int w, input int h);
        @(posedge clk); #1;
        img_width = CW'(w); img_height = ROW_BIT'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams w*h pixels; returns early after rst_at accepted pixels when rst_at > 0.
    task automatic run_frame(input int w, input int h, input bit toggle,
                             input int rst_at, input int chg_w);
        int p = 0;
        int cyc = 0;
        cur_w = w;
        snap();
        pulse_start(w, h);
        while (p < w * h && cyc < 4000) begin
            @(posedge clk); #1;
            pix_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            pix_data  = WIDTH'(p + 1);
            if (chg_w > 0 && p == 10) img_width = CW'(chg_w);
            @(negedge clk);
            if (pix_valid && pix_ready) p++;
            cyc++;
            if (rst_at > 0 && p == rst_at) break;
        end
        if (rst_at == 0) begin
            check("frame_pixels_accepted", p, w * h);
            @(posedge clk); #1;
            pix_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic check_frame(input string nm, input int w, input int h);
        check({nm, "_windows"}, n_win - b_win, (w - 2) * (h - 2));
        check({nm, "_win_seq_errs"}, n_bad_win - b_bad_win, 0);
        check({nm, "_writes"}, n_wen - b_wen, w * h);
        check({nm, "_bad_ren"}, n_bad_ren - b_bad_ren, 0);
        check({nm, "_line_delay_errs"}, n_bad_data - b_data, 0);
        check({nm, "_frame_done"}, n_done - b_done, 1);
        check({nm, "_done_after_last"}, done_wen, w * h);
        check({nm, "_cfg_err"}, n_err - b_err, 0);
    endtask

    task automatic bad_cfg(input string nm, input int w, input int h);
        snap();
        pulse_start(w, h);
        pix_valid = 1'b1;
        repeat (6) @(negedge clk);
        pix_valid = 1'b0;
        check({nm, "_cfg_err"}, n_err - b_err, 1);
        check({nm, "_ready"}, n_ready - b_ready, 0);
        check({nm, "_writes"}, n_wen - b_wen, 0);
    endtask

    initial begin
        #12;
        // Reset state
        check("rst_pix_ready", int'(pix_ready), 0);
        check("rst_fifo_depth", int'(fifo_depth), 0);
        check("rst_win_valid", int'(win_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        do_reset();

        // 1: continuous stream
        run_frame(8, 4, 1'b0, 0, 0);
        check_frame("c1", 8, 4);
        check("c1_fifo_depth", int'(fifo_depth), 8);

        // 2: bubbles every other cycle
        do_reset();
        run_frame(8, 4, 1'b1, 0, 0);
        check_frame("c2", 8, 4);
        check("c2_max_count", frame_max, 8);

        // 3: rejected configurations
        do_reset();
        bad_cfg("c3_w2", 2, 4);
        bad_cfg("c3_w17", 17, 4);
        bad_cfg("c3_h2", 8, 2);

        // 4: line length equal to fifo depth
        do_reset();
        run_frame(16, 3, 1'b0, 0, 0);
        check_frame("c4", 16, 3);
        check("c4_ready_while_full", int'(n_full_ready - b_full_ready > 0), 1);

        // 5: reset mid-frame, then a clean frame
        do_reset();
        run_frame(8, 4, 1'b0, 20, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("c5_rst_ready", int'(pix_ready), 0);
        check("c5_rst_wen", int'(fifo_wen), 0);
        check("c5_rst_ren", int'(fifo_ren), 0);
        check("c5_rst_fifo_in", int'(fifo_in), 0);
        check("c5_rst_depth", int'(fifo_depth), 0);
        check("c5_rst_win", int'({win_valid, win_row, win_col}), 0);
        check("c5_rst_done", int'(frame_done), 0);
        @(posedge clk); #1;
        rst = 1'b0; pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("c5_no_frame_done", n_done - b_done, 0);
        run_frame(8, 4, 1'b0, 0, 0);
        check_frame("c5", 8, 4);

        // 6: width port changed mid-frame
        do_reset();
        run_frame(8, 4, 1'b0, 0, 5);
        check_frame("c6", 8, 4);
        check("c6_fifo_depth", int'(fifo_depth), 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
